// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
// Purpose : shared widths, types and small helpers for the register file.
//           Register pairs are formed as {R[2k+1] high byte, R[2k] low byte}.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package register_file_pkg;

   localparam int REG_W  = 8;
   localparam int ADDR_W = 16;
   localparam int NREGS  = 8;
   localparam int SEL_W  = 3;
   localparam int PAIR_W = 2;

   typedef logic [REG_W-1:0]  reg_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [PAIR_W-1:0] pair_t;

   // Glue a high and low byte into a 16-bit pair value.
   function automatic addr_t join_pair(input reg_t hi, input reg_t lo);
      return {hi, lo};
   endfunction

   // Pick the high (hi=1) or low (hi=0) byte of a pair value.
   function automatic reg_t pair_byte(input addr_t value, input logic hi);
      reg_t result;
      if (hi) begin
         result = value[ADDR_W-1:REG_W];
      end else begin
         result = value[REG_W-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/register_file_if.sv
// ---------------------------------------------------------------------------
// register_file_if
// Purpose : bundles the control selects and the four pass-through buses
//           (MAIN, LHS, RHS, ADDR) of the register file.
// Modports: master - the block driving controls/upstream buses, reading outputs
//           slave  - the register file itself
// ---------------------------------------------------------------------------
interface register_file_if;
   import register_file_pkg::*;

   logic  MAIN_LOAD_bar;
   sel_t  MAIN_LOAD_SEL;
   logic  MAIN_ASSERT_bar;
   sel_t  MAIN_ASSERT_SEL;
   logic  LHS_ASSERT_bar;
   sel_t  LHS_ASSERT_SEL;
   logic  RHS_ASSERT_bar;
   sel_t  RHS_ASSERT_SEL;
   logic  ADDR_LOAD_bar;
   sel_t  ADDR_LOAD_SEL;
   logic  ADDR_ASSERT_bar;
   sel_t  ADDR_ASSERT_SEL;
   logic  ADDR_INC;
   sel_t  ADDR_INC_SEL;

   reg_t  MAIN_in;
   reg_t  LHS_in;
   reg_t  RHS_in;
   addr_t ADDR_in;

   reg_t  MAIN_out;
   reg_t  LHS_out;
   reg_t  RHS_out;
   addr_t ADDR_out;

   modport master (
      output MAIN_LOAD_bar, MAIN_LOAD_SEL, MAIN_ASSERT_bar, MAIN_ASSERT_SEL,
      output LHS_ASSERT_bar, LHS_ASSERT_SEL, RHS_ASSERT_bar, RHS_ASSERT_SEL,
      output ADDR_LOAD_bar, ADDR_LOAD_SEL, ADDR_ASSERT_bar, ADDR_ASSERT_SEL,
      output ADDR_INC, ADDR_INC_SEL,
      output MAIN_in, LHS_in, RHS_in, ADDR_in,
      input  MAIN_out, LHS_out, RHS_out, ADDR_out
   );

   modport slave (
      input  MAIN_LOAD_bar, MAIN_LOAD_SEL, MAIN_ASSERT_bar, MAIN_ASSERT_SEL,
      input  LHS_ASSERT_bar, LHS_ASSERT_SEL, RHS_ASSERT_bar, RHS_ASSERT_SEL,
      input  ADDR_LOAD_bar, ADDR_LOAD_SEL, ADDR_ASSERT_bar, ADDR_ASSERT_SEL,
      input  ADDR_INC, ADDR_INC_SEL,
      input  MAIN_in, LHS_in, RHS_in, ADDR_in,
      output MAIN_out, LHS_out, RHS_out, ADDR_out
   );

endinterface

// File: rtl/register_file_bus_driver.sv
// ---------------------------------------------------------------------------
// bus_driver
// Purpose : active-low assert mux. When assert_bar is low the register value
//           drives the bus; otherwise the upstream bus value passes through.
// Ports   : assert_bar (1)  - active-low drive enable
//           reg_value  (W)  - value to drive when asserted
//           bus_in     (W)  - upstream bus value
//           bus_out    (W)  - resulting bus value
// ---------------------------------------------------------------------------
module bus_driver #(
   parameter int W = 8
) (
   input  logic         assert_bar,
   input  logic [W-1:0] reg_value,
   input  logic [W-1:0] bus_in,
   output logic [W-1:0] bus_out
);

   // Select register value or pass-through.
   always_comb begin
      if (!assert_bar) begin
         bus_out = reg_value;
      end else begin
         bus_out = bus_in;
      end
   end

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// Purpose : eight 8-bit registers R0..R7, also addressable as four 16-bit
//           pairs P0..P3 = {R[2k+1], R[2k]}. Byte writes from MAIN, pair
//           writes and pair increments on the ADDR side; four combinational
//           read buses with pass-through when not asserted.
// Ports   : CLK  - clock, state changes on rising edge
//           RST  - synchronous active-high reset, clears all registers
//           bus  - register_file_if.slave (controls, *_in, *_out)
// ---------------------------------------------------------------------------
module register_file
   import register_file_pkg::*;
(
   input logic            CLK,
   input logic            RST,
   register_file_if.slave bus
);

   reg_t  regs_r     [NREGS];
   reg_t  regs_nxt_s [NREGS];
   addr_t inc_pair_s;
   addr_t addr_pair_s;
   sel_t  idx_s;
   logic  unused_sel_bits_s;

   // Pair selects only use SEL[2:1]; bit 0 is deliberately ignored.
   assign unused_sel_bits_s = ^{bus.ADDR_LOAD_SEL[0], bus.ADDR_ASSERT_SEL[0],
                                bus.ADDR_INC_SEL[0]};

   // Increment is always computed from the pre-edge pair value.
   assign inc_pair_s = join_pair(regs_r[{bus.ADDR_INC_SEL[2:1], 1'b1}],
                                 regs_r[{bus.ADDR_INC_SEL[2:1], 1'b0}])
                       + {{(ADDR_W-1){1'b0}}, 1'b1};

   assign addr_pair_s = join_pair(regs_r[{bus.ADDR_ASSERT_SEL[2:1], 1'b1}],
                                  regs_r[{bus.ADDR_ASSERT_SEL[2:1], 1'b0}]);

   // Per-byte next value: ADDR_LOAD beats MAIN_LOAD beats ADDR_INC.
   // A byte not claimed by a higher-priority write still takes its half of
   // the incremented pair, so a carry into a loaded high byte is simply lost.
   always_comb begin
      idx_s = {SEL_W{1'b0}};
      for (int i = 0; i < NREGS; i++) begin
         idx_s = SEL_W'(i);
         if (!bus.ADDR_LOAD_bar && (idx_s[2:1] == bus.ADDR_LOAD_SEL[2:1])) begin
            regs_nxt_s[i] = pair_byte(bus.ADDR_in, idx_s[0]);
         end else if (!bus.MAIN_LOAD_bar && (idx_s == bus.MAIN_LOAD_SEL)) begin
            regs_nxt_s[i] = bus.MAIN_in;
         end else if (bus.ADDR_INC && (idx_s[2:1] == bus.ADDR_INC_SEL[2:1])) begin
            regs_nxt_s[i] = pair_byte(inc_pair_s, idx_s[0]);
         end else begin
            regs_nxt_s[i] = regs_r[i];
         end
      end
   end

   // Register state; reset overrides every write in the same cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {REG_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= regs_nxt_s[i];
         end
      end
   end

   bus_driver #(.W(REG_W)) u_main_drv (
      .assert_bar (bus.MAIN_ASSERT_bar),
      .reg_value  (regs_r[bus.MAIN_ASSERT_SEL]),
      .bus_in     (bus.MAIN_in),
      .bus_out    (bus.MAIN_out)
   );

   bus_driver #(.W(REG_W)) u_lhs_drv (
      .assert_bar (bus.LHS_ASSERT_bar),
      .reg_value  (regs_r[bus.LHS_ASSERT_SEL]),
      .bus_in     (bus.LHS_in),
      .bus_out    (bus.LHS_out)
   );

   bus_driver #(.W(REG_W)) u_rhs_drv (
      .assert_bar (bus.RHS_ASSERT_bar),
      .reg_value  (regs_r[bus.RHS_ASSERT_SEL]),
      .bus_in     (bus.RHS_in),
      .bus_out    (bus.RHS_out)
   );

   bus_driver #(.W(ADDR_W)) u_addr_drv (
      .assert_bar (bus.ADDR_ASSERT_bar),
      .reg_value  (addr_pair_s),
      .bus_in     (bus.ADDR_in),
      .bus_out    (bus.ADDR_out)
   );

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Self-checking bench: directed scenarios followed by random cycles, all
// compared against a byte-array model of the eight registers.
// ---------------------------------------------------------------------------
module tb_register_file;

   logic CLK;
   logic RST;
   int   checks;
   int   errors;
   int   mem [8];

   register_file_if bus ();

   register_file dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int pair_val(input int k);
      return mem[2*k+1] * 256 + mem[2*k];
   endfunction

   // Compare all four output buses with the model's expectation.
   task automatic check_outputs(input string tag);
      int e_main, e_lhs, e_rhs, e_addr;
      e_main = bus.MAIN_ASSERT_bar ? int'(bus.MAIN_in) : mem[bus.MAIN_ASSERT_SEL];
      e_lhs  = bus.LHS_ASSERT_bar  ? int'(bus.LHS_in)  : mem[bus.LHS_ASSERT_SEL];
      e_rhs  = bus.RHS_ASSERT_bar  ? int'(bus.RHS_in)  : mem[bus.RHS_ASSERT_SEL];
      e_addr = bus.ADDR_ASSERT_bar ? int'(bus.ADDR_in) : pair_val(int'(bus.ADDR_ASSERT_SEL) / 2);
      check({tag, ".main"}, {8'h00, bus.MAIN_out}, 16'(e_main));
      check({tag, ".lhs"},  {8'h00, bus.LHS_out},  16'(e_lhs));
      check({tag, ".rhs"},  {8'h00, bus.RHS_out},  16'(e_rhs));
      check({tag, ".addr"}, bus.ADDR_out,          16'(e_addr));
   endtask

   // Advance one clock edge and update the model from the applied controls.
   task automatic tick();
      int nxt [8];
      int k, v;
      nxt = mem;
      if (bus.ADDR_INC) begin
         k = int'(bus.ADDR_INC_SEL) / 2;
         v = (pair_val(k) + 1) % 65536;
         nxt[2*k]   = v % 256;
         nxt[2*k+1] = v / 256;
      end
      if (!bus.MAIN_LOAD_bar) nxt[bus.MAIN_LOAD_SEL] = int'(bus.MAIN_in);
      if (!bus.ADDR_LOAD_bar) begin
         k = int'(bus.ADDR_LOAD_SEL) / 2;
         nxt[2*k]   = int'(bus.ADDR_in) % 256;
         nxt[2*k+1] = int'(bus.ADDR_in) / 256;
      end
      if (RST) begin
         for (int i = 0; i < 8; i++) nxt[i] = 0;
      end
      @(posedge CLK);
      mem = nxt;
      @(negedge CLK);
   endtask

   task automatic set_idle();
      RST = 1'b0;
      bus.MAIN_LOAD_bar = 1'b1;   bus.MAIN_LOAD_SEL = 3'd0;
      bus.MAIN_ASSERT_bar = 1'b1; bus.MAIN_ASSERT_SEL = 3'd0;
      bus.LHS_ASSERT_bar = 1'b1;  bus.LHS_ASSERT_SEL = 3'd0;
      bus.RHS_ASSERT_bar = 1'b1;  bus.RHS_ASSERT_SEL = 3'd0;
      bus.ADDR_LOAD_bar = 1'b1;   bus.ADDR_LOAD_SEL = 3'd0;
      bus.ADDR_ASSERT_bar = 1'b1; bus.ADDR_ASSERT_SEL = 3'd0;
      bus.ADDR_INC = 1'b0;        bus.ADDR_INC_SEL = 3'd0;
      bus.MAIN_in = 8'($urandom);
      bus.LHS_in  = 8'($urandom);
      bus.RHS_in  = 8'($urandom);
      bus.ADDR_in = 16'($urandom);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      CLK = 1'b0;
      set_idle();
      @(negedge CLK);

      // Reset: outputs pass through while reset is applied.
      RST = 1'b1;
      #1 check_outputs("rst_passthru");
      tick();
      RST = 1'b0;

      // Every register and pair reads zero after reset.
      for (int i = 0; i < 8; i++) begin
         bus.MAIN_ASSERT_bar = 1'b0; bus.MAIN_ASSERT_SEL = 3'(i);
         bus.LHS_ASSERT_bar  = 1'b0; bus.LHS_ASSERT_SEL  = 3'(i);
         bus.RHS_ASSERT_bar  = 1'b0; bus.RHS_ASSERT_SEL  = 3'(i);
         bus.ADDR_ASSERT_bar = 1'b0; bus.ADDR_ASSERT_SEL = 3'(i);
         #1;
         check("rst_main", {8'h00, bus.MAIN_out}, 16'h0000);
         check("rst_lhs",  {8'h00, bus.LHS_out},  16'h0000);
         check("rst_rhs",  {8'h00, bus.RHS_out},  16'h0000);
         check("rst_addr", bus.ADDR_out,          16'h0000);
      end
      @(negedge CLK);

      // MAIN_LOAD R3 <= A5; same-cycle assert of R3 still shows old value.
      set_idle();
      bus.MAIN_LOAD_bar = 1'b0; bus.MAIN_LOAD_SEL = 3'd3; bus.MAIN_in = 8'hA5;
      bus.LHS_ASSERT_bar = 1'b0; bus.LHS_ASSERT_SEL = 3'd3;
      #1 check("no_bypass", {8'h00, bus.LHS_out}, 16'h0000);
      tick();
      set_idle();
      bus.LHS_ASSERT_bar = 1'b0;  bus.LHS_ASSERT_SEL = 3'd3;
      bus.RHS_ASSERT_bar = 1'b0;  bus.RHS_ASSERT_SEL = 3'd2;
      bus.ADDR_ASSERT_bar = 1'b0; bus.ADDR_ASSERT_SEL = 3'd2;
      #1;
      check("lhs_r3", {8'h00, bus.LHS_out}, 16'h00A5);
      check("rhs_r2", {8'h00, bus.RHS_out}, 16'h0000);
      check("addr_p1", bus.ADDR_out, 16'hA500);
      check_outputs("load_r3");

      // ADDR_LOAD P2 <= 12FF, then increment with SEL=5 (bit 0 ignored).
      set_idle();
      bus.ADDR_LOAD_bar = 1'b0; bus.ADDR_LOAD_SEL = 3'd4; bus.ADDR_in = 16'h12FF;
      tick();
      set_idle();
      bus.ADDR_INC = 1'b1; bus.ADDR_INC_SEL = 3'd5;
      tick();
      set_idle();
      bus.ADDR_ASSERT_bar = 1'b0; bus.ADDR_ASSERT_SEL = 3'd4;
      bus.MAIN_ASSERT_bar = 1'b0; bus.MAIN_ASSERT_SEL = 3'd4;
      bus.LHS_ASSERT_bar  = 1'b0; bus.LHS_ASSERT_SEL  = 3'd5;
      bus.RHS_ASSERT_bar  = 1'b0; bus.RHS_ASSERT_SEL  = 3'd5;
      #1;
      check("inc_carry", bus.ADDR_out, 16'h1300);
      check("inc_r4", {8'h00, bus.MAIN_out}, 16'h0000);
      check("inc_r5", {8'h00, bus.LHS_out}, 16'h0013);
      check("same_sel_rhs", {8'h00, bus.RHS_out}, 16'h0013);

      // Priority: increment P2 while MAIN_LOAD overrides its high byte.
      set_idle();
      bus.ADDR_INC = 1'b1; bus.ADDR_INC_SEL = 3'd4;
      bus.MAIN_LOAD_bar = 1'b0; bus.MAIN_LOAD_SEL = 3'd5; bus.MAIN_in = 8'h99;
      tick();
      set_idle();
      bus.ADDR_ASSERT_bar = 1'b0; bus.ADDR_ASSERT_SEL = 3'd4;
      #1 check("prio_main_over_inc", bus.ADDR_out, 16'h9901);

      // Priority: ADDR_LOAD beats MAIN_LOAD on the same byte.
      set_idle();
      bus.ADDR_LOAD_bar = 1'b0; bus.ADDR_LOAD_SEL = 3'd0; bus.ADDR_in = 16'h4321;
      bus.MAIN_LOAD_bar = 1'b0; bus.MAIN_LOAD_SEL = 3'd1; bus.MAIN_in = 8'hEE;
      tick();
      set_idle();
      bus.ADDR_ASSERT_bar = 1'b0; bus.ADDR_ASSERT_SEL = 3'd1;
      #1 check("prio_addr_over_main", bus.ADDR_out, 16'h4321);

      // Wrap: FFFF + 1 -> 0000, old value visible until the edge.
      set_idle();
      bus.ADDR_LOAD_bar = 1'b0; bus.ADDR_LOAD_SEL = 3'd6; bus.ADDR_in = 16'hFFFF;
      tick();
      set_idle();
      bus.ADDR_INC = 1'b1; bus.ADDR_INC_SEL = 3'd6;
      bus.ADDR_ASSERT_bar = 1'b0; bus.ADDR_ASSERT_SEL = 3'd6;
      #1 check("wrap_pre", bus.ADDR_out, 16'hFFFF);
      tick();
      bus.ADDR_INC = 1'b0;
      #1 check("wrap_post", bus.ADDR_out, 16'h0000);

      // Pass-through with everything deasserted.
      set_idle();
      bus.MAIN_in = 8'h5A; bus.ADDR_in = 16'hBEEF;
      #1;
      check("pass_main", {8'h00, bus.MAIN_out}, 16'h005A);
      check("pass_addr", bus.ADDR_out, 16'hBEEF);

      // Reset wins over simultaneous loads.
      set_idle();
      bus.ADDR_LOAD_bar = 1'b0; bus.ADDR_LOAD_SEL = 3'd2; bus.ADDR_in = 16'h1111;
      bus.MAIN_LOAD_bar = 1'b0; bus.MAIN_LOAD_SEL = 3'd2; bus.MAIN_in = 8'h77;
      RST = 1'b1;
      tick();
      set_idle();
      for (int i = 0; i < 8; i++) begin
         bus.MAIN_ASSERT_bar = 1'b0; bus.MAIN_ASSERT_SEL = 3'(i);
         #1 check("rst_over_load", {8'h00, bus.MAIN_out}, 16'h0000);
      end
      @(negedge CLK);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         RST = ($urandom_range(0, 31) == 0);
         bus.MAIN_LOAD_bar   = 1'($urandom);  bus.MAIN_LOAD_SEL   = 3'($urandom);
         bus.MAIN_ASSERT_bar = 1'($urandom);  bus.MAIN_ASSERT_SEL = 3'($urandom);
         bus.LHS_ASSERT_bar  = 1'($urandom);  bus.LHS_ASSERT_SEL  = 3'($urandom);
         bus.RHS_ASSERT_bar  = 1'($urandom);  bus.RHS_ASSERT_SEL  = 3'($urandom);
         bus.ADDR_LOAD_bar   = ($urandom_range(0, 3) != 0);
         bus.ADDR_LOAD_SEL   = 3'($urandom);
         bus.ADDR_ASSERT_bar = 1'($urandom);  bus.ADDR_ASSERT_SEL = 3'($urandom);
         bus.ADDR_INC        = ($urandom_range(0, 2) == 0);
         bus.ADDR_INC_SEL    = 3'($urandom);
         bus.MAIN_in = 8'($urandom);
         bus.LHS_in  = 8'($urandom);
         bus.RHS_in  = 8'($urandom);
         bus.ADDR_in = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         #1 check_outputs("rand");
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL: CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL: RST, input, 1, reset; one clock, synchronous, active-high.
REQ-003 SHALL: MAIN_LOAD_bar, input, 1, active-low write enable for the byte register selected by MAIN_LOAD_SEL.
REQ-004 SHALL: MAIN_LOAD_SEL, input, 3, byte register index R0..R7 for MAIN writes.
REQ-005 SHALL: MAIN_ASSERT_bar / MAIN_ASSERT_SEL, input, 1 / 3, active-low drive of R[MAIN_ASSERT_SEL] onto MAIN_out.
REQ-006 SHALL: LHS_ASSERT_bar / LHS_ASSERT_SEL, input, 1 / 3, active-low drive of R[LHS_ASSERT_SEL] onto LHS_out.
REQ-007 SHALL: RHS_ASSERT_bar / RHS_ASSERT_SEL, input, 1 / 3, active-low drive of R[RHS_ASSERT_SEL] onto RHS_out.
REQ-008 SHALL: ADDR_LOAD_bar / ADDR_LOAD_SEL, input, 1 / 3, active-low 16-bit write of the selected register pair from ADDR_in.
REQ-009 SHALL: ADDR_ASSERT_bar / ADDR_ASSERT_SEL, input, 1 / 3, active-low drive of the selected register pair onto ADDR_out.
REQ-010 SHALL: ADDR_INC / ADDR_INC_SEL, input, 1 / 3, active-high increment of the selected register pair.
REQ-011 SHALL: MAIN_in, LHS_in, RHS_in (8), ADDR_in (16), inputs, upstream bus values.
REQ-012 SHALL: MAIN_out, LHS_out, RHS_out (8), ADDR_out (16), outputs, bus values after this block.

Function
REQ-013 SHALL: state is eight 8-bit registers R0..R7; no other state.
REQ-014 SHALL: pair Pk (k = SEL[2:1]) = {R[2k+1] high byte, R[2k] low byte}; SEL[0] ignored for all ADDR_* selects.
REQ-015 SHALL: each *_out is combinational: asserted (bar=0) -> selected register/pair current value; deasserted -> equal to matching *_in (pass-through); no tri-state.
REQ-016 SHALL: reads return pre-edge contents; a write becomes visible on outputs the cycle after the edge that performs it (zero-cycle read, one-cycle write latency).
REQ-017 SHALL: MAIN_LOAD_bar=0 at edge -> R[MAIN_LOAD_SEL] <= MAIN_in.
REQ-018 SHALL: ADDR_LOAD_bar=0 at edge -> selected pair <= ADDR_in.
REQ-019 SHALL: ADDR_INC=1 at edge -> selected pair <= pair + 1, modulo 2^16 (0xFFFF -> 0x0000, carry low->high byte).
REQ-020 SHALL: simultaneous writes resolved per byte, priority RST > ADDR_LOAD > MAIN_LOAD > ADDR_INC; increment result computed from pre-edge pair value, non-overridden byte still takes incremented value.
REQ-021 SHALL: asserting a register while loading it in same cycle outputs the old value (no write-through bypass).
REQ-022 SHALL: LHS and RHS may select the same register; both outputs show it.

Reset
REQ-023 SHALL: RST=1 at rising edge -> R0..R7 <= 0x00, overriding all loads/increments that cycle.
REQ-024 SHALL: outputs remain combinational during reset (pass-through or 0x00 register value per assert controls).
REQ-025 SHALL: no state changes without a rising CLK edge; reset asserted mid-operation discards in-flight increments.

Structure
REQ-026 SHALL: shared package holds REG_W=8, ADDR_W=16, NREGS=8, SEL_W=3 constants.
REQ-027 SHALL: single module; optional sub-module bus_driver (assert-bar mux with pass-through) instantiated four times.

Verification
REQ-028 SHALL: RST=1 one edge, then MAIN/LHS/RHS assert R0..R7 in turn -> 0x00 each; ADDR assert P0..P3 -> 0x0000.
REQ-029 SHALL: MAIN_LOAD R3<=0xA5, then LHS_SEL=3, RHS_SEL=2 asserted -> LHS_out=0xA5, RHS_out=0x00; ADDR assert SEL=2 -> 0xA500.
REQ-030 SHALL: ADDR_LOAD SEL=4 with 0x12FF, then ADDR_INC SEL=5 -> ADDR_out=0x1300, R4=0x00, R5=0x13.
REQ-031 SHALL: pair=0xFFFF, ADDR_INC -> 0x0000 next cycle.
REQ-032 SHALL: all assert_bar=1, MAIN_in=0x5A, ADDR_in=0xBEEF -> MAIN_out=0x5A, ADDR_out=0xBEEF.
REQ-033 SHALL: same edge ADDR_LOAD P1<=0x1111, MAIN_LOAD R2<=0x77, RST=1 -> all registers 0x00.
